mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle main control FSM for the Small-MIPS core. Decodes the 6-bit opcode and sequences each
//  instruction through fetch/decode/execute/memory/writeback. Directly upstream of aluControl: drives
//  o_aluOp (00=add, 01=sub, 10=use funct) plus all datapath enables and muxes. Stalls on a memory-ready handshake.
// PARAMETERS
//  MEM_WAIT   1         1: memory states wait for i_memReady; 0: i_memReady treated as constant 1
//  OP_RTYPE   6'b000000 R-type opcode
//  OP_LW      6'b100011 load word
//  OP_SW      6'b101011 store word
//  OP_BEQ     6'b000100 branch if equal
//  OP_ADDI    6'b001000 add immediate
//  OP_J       6'b000010 jump
// PORTS
//  i_clk       in   1  clock, rising edge
//  i_rst       in   1  asynchronous reset, active-high
//  i_opcode    in   6  IR[31:26], valid from DECODE onward
//  i_zero      in   1  ALU zero flag, sampled in BRANCH
//  i_memReady  in   1  memory completes access this cycle
//  o_aluOp     out  2  to aluControl.i_aluOp
//  o_aluSrcA   out  1  0=PC, 1=regA
//  o_aluSrcB   out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  o_pcSrc     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  o_pcEn      out  1  PC load = pcWrite | (branch & i_zero)
//  o_iord      out  1  memory address: 0=PC, 1=ALUOut
//  o_memRead   out  1  memory read strobe
//  o_memWrite  out  1  memory write strobe
//  o_irWrite   out  1  instruction register load
//  o_regDst    out  1  write reg: 0=rt, 1=rd
//  o_memToReg  out  1  writeback data: 0=ALUOut, 1=MDR
//  o_regWrite  out  1  register file write enable
//  o_illegal   out  1  one-cycle pulse on unknown opcode in DECODE
//  o_state     out  4  current state encoding (debug)
// BEHAVIOUR
//  - Moore FSM, one state register; all outputs combinational from state (+i_memReady/i_zero where noted).
//  - Reset: state=RESET(0). In RESET every output is 0. RESET -> FETCH on the first clock after i_rst falls.
//  - Defaults (any signal not listed for a state) are 0.
//  - FETCH(1): memRead=1, iord=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite=pcEn=i_memReady.
//    Stay while !i_memReady, else -> DECODE.
//  - DECODE(2): aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next by opcode:
//    LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->FETCH with o_illegal=1.
//  - MEMADR(3): aluSrcA=1, aluSrcB=10, aluOp=00. LW->MEMRD, SW->MEMWR.
//  - MEMRD(4): memRead=1, iord=1. Stay while !i_memReady, else -> MEMWB.
//  - MEMWB(5): regDst=0, memToReg=1, regWrite=1. -> FETCH.
//  - MEMWR(6): memWrite=1, iord=1, held through the wait. Stay while !i_memReady, else -> FETCH.
//  - EXECUTE(7): aluSrcA=1, aluSrcB=00, aluOp=10. -> ALUWB.
//  - ALUWB(8): regDst=1, memToReg=0, regWrite=1. -> FETCH.
//  - BRANCH(9): aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01; o_pcEn=i_zero. -> FETCH.
//  - ADDIEX(10): aluSrcA=1, aluSrcB=10, aluOp=00. -> ADDIWB.
//  - ADDIWB(11): regDst=0, memToReg=0, regWrite=1. -> FETCH.
//  - JUMP(12): pcSrc=10, o_pcEn=1. -> FETCH.
//  - Codes 13-15 are unreachable; if ever entered, go to FETCH with all outputs 0.
//  - Cycle counts with no waits: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3; each wait cycle adds 1.
//  - Never more than one of memRead/memWrite is high. regWrite is never high in the same cycle as memWrite.
//  - i_rst asserted mid-instruction: state goes to RESET immediately and all outputs drop to 0 asynchronously.
//    No partial write completes.
//  - MEM_WAIT=0: every memory state takes exactly one cycle.
// TESTING
//  - Reset then release: o_state 0->1. In RESET all outputs=0. After release: FETCH with i_memReady=1 gives irWrite=pcEn=1, aluSrcB=01.
//  - LW (100011), memReady=1: states 1,2,3,4,5,1. At state 5: regWrite=1, memToReg=1, regDst=0.
//  - SW with i_memReady low for 3 cycles in MEMWR: memWrite=1 for 4 cycles, then FETCH. regWrite stays 0.
//  - R-type: EXECUTE has aluOp=10. ALUWB has regDst=1, regWrite=1. BEQ with i_zero=0 gives pcEn=0 in BRANCH; with i_zero=1 gives pcEn=1, pcSrc=01, aluOp=01.
//  - Opcode 6'b111111 in DECODE: o_illegal pulses 1 cycle, next state FETCH, no regWrite/memWrite.
//  - Assert i_rst in MEMWR with memWrite=1: memWrite drops same cycle, o_state=0. J: JUMP has pcSrc=10, pcEn=1.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle main control FSM for Small-MIPS: sequences fetch/decode/execute/memory/writeback.
// Moore outputs from state, with FETCH/BRANCH strobes qualified by memory-ready/zero; memory states stall on i_memReady.
module mips_mc_control #(
    parameter int          MEM_WAIT = 1,
    parameter logic [5:0]  OP_RTYPE = 6'b000000,
    parameter logic [5:0]  OP_LW    = 6'b100011,
    parameter logic [5:0]  OP_SW    = 6'b101011,
    parameter logic [5:0]  OP_BEQ   = 6'b000100,
    parameter logic [5:0]  OP_ADDI  = 6'b001000,
    parameter logic [5:0]  OP_J     = 6'b000010
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic [1:0] o_aluOp,
    output logic       o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_pcSrc,
    output logic       o_pcEn,
    output logic       o_iord,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_regWrite,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   mem_rdy;

    // With MEM_WAIT=0 every memory access is assumed to finish in its first cycle.
    assign mem_rdy = (MEM_WAIT != 0) ? i_memReady : 1'b1;
    assign o_state = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        o_aluOp    = 2'b00;
        o_aluSrcA  = 1'b0;
        o_aluSrcB  = 2'b00;
        o_pcSrc    = 2'b00;
        o_pcEn     = 1'b0;
        o_iord     = 1'b0;
        o_memRead  = 1'b0;
        o_memWrite = 1'b0;
        o_irWrite  = 1'b0;
        o_regDst   = 1'b0;
        o_memToReg = 1'b0;
        o_regWrite = 1'b0;
        o_illegal  = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = 2'b01;
                o_irWrite = mem_rdy;
                o_pcEn    = mem_rdy;
                state_d   = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_aluSrcB = 2'b11;
                if (i_opcode == OP_LW || i_opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (i_opcode == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (i_opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (i_opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (i_opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    o_illegal = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMADR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                state_d   = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                o_memRead = 1'b1;
                o_iord    = 1'b1;
                state_d   = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                o_memToReg = 1'b1;
                o_regWrite = 1'b1;
            end
            S_MEMWR: begin
                o_memWrite = 1'b1;
                o_iord     = 1'b1;
                state_d    = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                o_regDst   = 1'b1;
                o_regWrite = 1'b1;
            end
            S_BRANCH: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b01;
                o_pcSrc   = 2'b01;
                o_pcEn    = i_zero;
            end
            S_ADDIEX: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: o_regWrite = 1'b1;
            S_JUMP: begin
                o_pcSrc = 2'b10;
                o_pcEn  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: instruction-sequence model checked every cycle plus literal spot checks.
module tb_mips_mc_control;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [5:0] i_opcode;
    logic       i_zero;
    logic       i_memReady;
    logic [1:0] o_aluOp;
    logic       o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_pcSrc;
    logic       o_pcEn, o_iord, o_memRead, o_memWrite, o_irWrite;
    logic       o_regDst, o_memToReg, o_regWrite, o_illegal;
    logic [3:0] o_state;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    mips_mc_control dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_zero(i_zero),
        .i_memReady(i_memReady), .o_aluOp(o_aluOp), .o_aluSrcA(o_aluSrcA),
        .o_aluSrcB(o_aluSrcB), .o_pcSrc(o_pcSrc), .o_pcEn(o_pcEn), .o_iord(o_iord),
        .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_irWrite(o_irWrite),
        .o_regDst(o_regDst), .o_memToReg(o_memToReg), .o_regWrite(o_regWrite),
        .o_illegal(o_illegal), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] pcSrc;
        logic       pcEn, iord, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegal;
    } ctl_t;

    ctl_t dut_c;
    assign dut_c = {o_aluOp, o_aluSrcA, o_aluSrcB, o_pcSrc, o_pcEn, o_iord, o_memRead,
                    o_memWrite, o_irWrite, o_regDst, o_memToReg, o_regWrite, o_illegal};

    int checks = 0;
    int errors = 0;

    // Instruction classes: 0 unknown, 1 LW, 2 SW, 3 R-type, 4 BEQ, 5 ADDI, 6 J.
    // Each row is the state walk of that class; its length is the no-wait cycle count.
    int seq [7][5] = '{'{1, 2, 0, 0, 0}, '{1, 2, 3, 4, 5}, '{1, 2, 3, 6, 0},
                       '{1, 2, 7, 8, 0}, '{1, 2, 9, 0, 0}, '{1, 2, 10, 11, 0},
                       '{1, 2, 12, 0, 0}};
    int len [7] = '{2, 5, 4, 4, 3, 4, 3};

    function automatic int cls_of(logic [5:0] op);
        case (op)
            OP_LW:   return 1;
            OP_SW:   return 2;
            OP_R:    return 3;
            OP_BEQ:  return 4;
            OP_ADDI: return 5;
            OP_J:    return 6;
            default: return 0;
        endcase
    endfunction

    function automatic int next_pos(int pos, logic [5:0] op, logic rdy);
        int c = pos / 8;
        int s = pos % 8;
        int st = seq[c][s];
        if ((st == 1 || st == 4 || st == 6) && !rdy) return pos;
        if (s == 1) return (cls_of(op) == 0) ? 0 : cls_of(op) * 8 + 2;
        if (s + 1 >= len[c]) return 0;
        return pos + 1;
    endfunction

    function automatic ctl_t exp_out(int st, logic [5:0] op, logic rdy, logic z);
        ctl_t c = '0;
        case (st)
            1:  begin c.memRead = 1; c.srcB = 2'b01; c.irWrite = rdy; c.pcEn = rdy; end
            2:  begin c.srcB = 2'b11; c.illegal = (cls_of(op) == 0); end
            3:  begin c.srcA = 1; c.srcB = 2'b10; end
            4:  begin c.memRead = 1; c.iord = 1; end
            5:  begin c.memToReg = 1; c.regWrite = 1; end
            6:  begin c.memWrite = 1; c.iord = 1; end
            7:  begin c.srcA = 1; c.aluOp = 2'b10; end
            8:  begin c.regDst = 1; c.regWrite = 1; end
            9:  begin c.srcA = 1; c.aluOp = 2'b01; c.pcSrc = 2'b01; c.pcEn = z; end
            10: begin c.srcA = 1; c.srcB = 2'b10; end
            11: c.regWrite = 1;
            12: begin c.pcSrc = 2'b10; c.pcEn = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    bit m_inrst = 1'b1;
    int m_pos = 0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_inrst <= 1'b1;
            m_pos   <= 0;
        end else if (m_inrst) begin
            m_inrst <= 1'b0;
            m_pos   <= 0;
        end else begin
            m_pos <= next_pos(m_pos, i_opcode, i_memReady);
        end
    end

    function automatic int m_state();
        return m_inrst ? 0 : seq[m_pos / 8][m_pos % 8];
    endfunction

    always @(negedge i_clk) begin
        ctl_t e;
        e = exp_out(m_state(), i_opcode, i_memReady, i_zero);
        checks++;
        if (o_state != 4'(m_state())) begin
            errors++;
            $display("FAIL model_state t=%0t: got %0d expected %0d", $time, o_state, m_state());
        end
        checks++;
        if (dut_c !== e) begin
            errors++;
            $display("FAIL model_outputs t=%0t state=%0d: got %h expected %h", $time, o_state, dut_c, e);
        end
        checks++;
        if ((o_memRead && o_memWrite) || (o_regWrite && o_memWrite)) begin
            errors++;
            $display("FAIL strobe_exclusive t=%0t: got rd=%0b wr=%0b rw=%0b expected no overlap",
                     $time, o_memRead, o_memWrite, o_regWrite);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input logic [5:0] op, input logic rdy, input logic z);
        @(posedge i_clk);
        #1;
        i_opcode   = op;
        i_memReady = rdy;
        i_zero     = z;
        #1;
    endtask

    initial begin
        int cnt;
        i_rst = 1'b1; i_opcode = OP_R; i_zero = 1'b0; i_memReady = 1'b1;
        repeat (2) @(posedge i_clk);
        #2;
        chk("reset_state", o_state, 0);
        chk("reset_outputs", int'(dut_c), 0);
        i_rst = 1'b0;

        tick(OP_LW, 1, 0);
        chk("fetch_state", o_state, 1);
        chk("fetch_irWrite", o_irWrite, 1);
        chk("fetch_pcEn", o_pcEn, 1);
        chk("fetch_aluSrcB", o_aluSrcB, 1);
        tick(OP_LW, 1, 0); chk("lw_s2", o_state, 2);
        tick(OP_LW, 1, 0); chk("lw_s3", o_state, 3);
        tick(OP_LW, 1, 0); chk("lw_s4", o_state, 4);
        tick(OP_LW, 1, 0); chk("lw_s5", o_state, 5);
        chk("lw_regWrite", o_regWrite, 1);
        chk("lw_memToReg", o_memToReg, 1);
        chk("lw_regDst", o_regDst, 0);
        tick(OP_LW, 0, 0);
        chk("lw_back_fetch", o_state, 1);
        chk("fetch_stall_irWrite", o_irWrite, 0);

        tick(OP_SW, 1, 0); chk("fetch_stall_hold", o_state, 1);
        tick(OP_SW, 1, 0); chk("sw_s2", o_state, 2);
        tick(OP_SW, 1, 0); chk("sw_s3", o_state, 3);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(OP_SW, (i == 3), 0);
            if (o_memWrite) cnt++;
            chk("sw_no_regWrite", o_regWrite, 0);
        end
        chk("sw_memWrite_cycles", cnt, 4);
        tick(OP_R, 1, 0); chk("sw_back_fetch", o_state, 1);

        tick(OP_R, 1, 0); chk("r_s2", o_state, 2);
        tick(OP_R, 1, 0); chk("r_exec_state", o_state, 7);
        chk("r_exec_aluOp", o_aluOp, 2);
        tick(OP_R, 1, 0); chk("r_wb_state", o_state, 8);
        chk("r_wb_regDst", o_regDst, 1);
        chk("r_wb_regWrite", o_regWrite, 1);
        tick(OP_BEQ, 1, 0); chk("r_back_fetch", o_state, 1);

        tick(OP_BEQ, 1, 0);
        tick(OP_BEQ, 1, 0); chk("beq0_state", o_state, 9);
        chk("beq0_pcEn", o_pcEn, 0);
        tick(OP_BEQ, 1, 0); chk("beq0_back_fetch", o_state, 1);
        tick(OP_BEQ, 1, 0);
        tick(OP_BEQ, 1, 1); chk("beq1_state", o_state, 9);
        chk("beq1_pcEn", o_pcEn, 1);
        chk("beq1_pcSrc", o_pcSrc, 1);
        chk("beq1_aluOp", o_aluOp, 1);

        tick(OP_ADDI, 1, 0); chk("beq1_back_fetch", o_state, 1);
        tick(OP_ADDI, 1, 0);
        tick(OP_ADDI, 1, 0); chk("addi_ex_state", o_state, 10);
        tick(OP_ADDI, 1, 0); chk("addi_wb_state", o_state, 11);
        chk("addi_wb_regWrite", o_regWrite, 1);

        tick(OP_BAD, 1, 0); chk("addi_back_fetch", o_state, 1);
        tick(OP_BAD, 1, 0); chk("illegal_decode", o_state, 2);
        chk("illegal_pulse", o_illegal, 1);
        tick(OP_BAD, 1, 0); chk("illegal_to_fetch", o_state, 1);
        chk("illegal_drop", o_illegal, 0);

        tick(OP_J, 1, 0);
        tick(OP_J, 1, 0); chk("j_state", o_state, 12);
        chk("j_pcSrc", o_pcSrc, 2);
        chk("j_pcEn", o_pcEn, 1);

        tick(OP_SW, 1, 0);
        tick(OP_SW, 1, 0);
        tick(OP_SW, 1, 0);
        tick(OP_SW, 0, 0); chk("rst_mid_in_memwr", o_state, 6);
        chk("rst_mid_memWrite_before", o_memWrite, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("rst_mid_memWrite_drop", o_memWrite, 0);
        chk("rst_mid_state", o_state, 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        tick(OP_R, 1, 0); chk("rst_release_fetch", o_state, 1);
        tick(OP_R, 1, 0);
        tick(OP_R, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
